// File: rtl/dance_pattern_synth.sv
`default_nettype none
// ============================================================================
// Module   : dance_pattern_synth
// Brief    : Step-sequenced multi-voice tone/noise synthesiser with decaying
//            envelopes, difficulty-gated voices and a saturating sample mixer.
// Revision : 1.0 - initial release
// ============================================================================
module dance_pattern_synth #(
    parameter int N_VOICES      = 4,
    parameter int STEPS         = 16,
    parameter int STEP_TICKS    = 4166666,
    parameter int LOOPS_PER_LVL = 4,
    parameter int PERIOD_W      = 19,
    parameter int ENV_W         = 16,
    parameter int DECAY_DIV     = 8,
    parameter int AMP_SHIFT     = 9,
    parameter int OUT_W         = 32
) (
    input  logic                                            CLOCK_50,
    input  logic                                            reset_n,
    input  logic                                            enable,
    input  logic                                            pat_we,
    input  logic [$clog2((N_VOICES > 1) ? N_VOICES : 2)-1:0] pat_voice,
    input  logic [$clog2(STEPS)-1:0]                        pat_step,
    input  logic [PERIOD_W:0]                               pat_wdata,
    output logic [OUT_W-1:0]                                out_sample,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [$clog2(STEPS)-1:0]                        step_idx,
    output logic                                            step_pulse,
    output logic [2:0]                                      level,
    output logic [N_VOICES-1:0]                             voice_active
);

    localparam int SIDX_W = $clog2(STEPS);
    localparam int TICK_W = $clog2((STEP_TICKS > 1) ? STEP_TICKS : 2);
    localparam int LOOP_W = $clog2((LOOPS_PER_LVL > 1) ? LOOPS_PER_LVL : 2);
    localparam int PRE_W  = $clog2((DECAY_DIV > 1) ? DECAY_DIV : 2);
    localparam int MIX_W  = OUT_W + 3;

    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(STEP_TICKS - 1);
    localparam logic [LOOP_W-1:0] c_LOOP_LAST = LOOP_W'(LOOPS_PER_LVL - 1);
    localparam logic [PRE_W-1:0]  c_PRE_LAST  = PRE_W'(DECAY_DIV - 1);
    localparam logic [SIDX_W-1:0] c_STEP_LAST = SIDX_W'(STEPS - 1);
    localparam logic [2:0]        c_LVL_MAX   = 3'(N_VOICES - 1);
    localparam logic [15:0]       c_LFSR_SEED = 16'hACE1;

    localparam logic signed [MIX_W-1:0] c_SAT_MAX = {4'b0000, {(OUT_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0] c_SAT_MIN = {4'b1111, {(OUT_W-1){1'b0}}};

    // Sequencer state: START emits the step-0 pulse on the first enabled cycle.
    localparam logic [0:0] c_ST_START = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              w_start_step;

    logic [TICK_W-1:0] r_tick;
    logic [SIDX_W-1:0] r_step_idx;
    logic              r_step_pulse;
    logic [LOOP_W-1:0] r_loop_cnt;
    logic [2:0]        r_level;
    logic [15:0]       r_lfsr;
    logic [PRE_W-1:0]  r_pre;
    logic              w_decay;

    logic [PERIOD_W:0]   r_pat  [N_VOICES][STEPS];
    logic [ENV_W-1:0]    r_env  [N_VOICES];
    logic [PERIOD_W-1:0] r_phase[N_VOICES];
    logic [PERIOD_W-1:0] r_period[N_VOICES];
    logic [N_VOICES-1:0] r_sign;
    logic [N_VOICES-1:0] r_mode;

    logic [PERIOD_W:0]   w_rd   [N_VOICES];
    logic [N_VOICES-1:0] w_unlocked;
    logic [N_VOICES-1:0] w_active;
    logic [N_VOICES-1:0] w_pos;
    logic [MIX_W-1:0]    w_amp  [N_VOICES];
    logic signed [MIX_W-1:0] w_sum;
    logic signed [MIX_W-1:0] w_sat;
    logic [OUT_W-1:0]    w_mix;

    logic [OUT_W-1:0]    r_sample;
    logic                r_valid;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_START: if (enable) w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_RUN;
        endcase
    end

    always_comb begin
        w_start_step = 1'b0;
        if (r_state == c_ST_START) begin
            w_start_step = enable;
        end
    end

    // ------------------------------------------------------------------
    // Step timer, loop counter and difficulty level
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_tick       <= '0;
            r_step_idx   <= '0;
            r_step_pulse <= 1'b0;
            r_loop_cnt   <= '0;
            r_level      <= '0;
        end else if (!enable) begin
            r_step_pulse <= 1'b0;
        end else if (w_start_step) begin
            r_tick       <= '0;
            r_step_pulse <= 1'b1;
        end else if (r_tick == c_TICK_LAST) begin
            r_tick       <= '0;
            r_step_idx   <= r_step_idx + 1'b1;
            r_step_pulse <= 1'b1;
            if (r_step_idx == c_STEP_LAST) begin
                if (r_loop_cnt == c_LOOP_LAST) begin
                    r_loop_cnt <= '0;
                    if (r_level < c_LVL_MAX) begin
                        r_level <= r_level + 1'b1;
                    end
                end else begin
                    r_loop_cnt <= r_loop_cnt + 1'b1;
                end
            end
        end else begin
            r_tick       <= r_tick + 1'b1;
            r_step_pulse <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Noise source and shared envelope prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= c_LFSR_SEED;
            r_pre  <= '0;
        end else if (enable) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_pre  <= (r_pre == c_PRE_LAST) ? '0 : r_pre + 1'b1;
        end
    end

    assign w_decay = enable && (r_pre == c_PRE_LAST);

    // ------------------------------------------------------------------
    // Pattern store: reads during the trigger cycle see pre-write contents
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < N_VOICES; v++) begin
                for (int s = 0; s < STEPS; s++) begin
                    r_pat[v][s] <= '0;
                end
            end
        end else if (pat_we && (int'(pat_voice) < N_VOICES)) begin
            r_pat[pat_voice][pat_step] <= pat_wdata;
        end
    end

    always_comb begin
        for (int v = 0; v < N_VOICES; v++) begin
            w_rd[v]       = r_pat[v][r_step_idx];
            w_unlocked[v] = (int'(r_level) >= v);
            w_active[v]   = (r_env[v] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Voices: trigger, square-wave phase and envelope decay
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < N_VOICES; v++) begin
                r_env[v]    <= '0;
                r_phase[v]  <= '0;
                r_period[v] <= '0;
            end
            r_sign <= '0;
            r_mode <= '0;
        end else begin
            for (int v = 0; v < N_VOICES; v++) begin
                if (!w_unlocked[v]) begin
                    r_env[v] <= '0;
                end else if (r_step_pulse && (w_rd[v][PERIOD_W-1:0] != '0)) begin
                    r_env[v]    <= '1;
                    r_phase[v]  <= '0;
                    r_sign[v]   <= 1'b1;
                    r_mode[v]   <= w_rd[v][PERIOD_W];
                    r_period[v] <= w_rd[v][PERIOD_W-1:0];
                end else if (enable) begin
                    if (r_phase[v] == r_period[v] - 1'b1) begin
                        r_phase[v] <= '0;
                        r_sign[v]  <= ~r_sign[v];
                    end else begin
                        r_phase[v] <= r_phase[v] + 1'b1;
                    end
                    if (w_decay && (r_env[v] != '0)) begin
                        r_env[v] <= r_env[v] - 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mixer: wide signed accumulation, then clamp to the output range
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            w_amp[v] = {{(MIX_W-ENV_W){1'b0}}, r_env[v]} << AMP_SHIFT;
            w_pos[v] = r_mode[v] ? r_lfsr[0] : r_sign[v];
            w_sum    = w_pos[v] ? (w_sum + $signed(w_amp[v])) : (w_sum - $signed(w_amp[v]));
        end
        if (w_sum > c_SAT_MAX) begin
            w_sat = c_SAT_MAX;
        end else if (w_sum < c_SAT_MIN) begin
            w_sat = c_SAT_MIN;
        end else begin
            w_sat = w_sum;
        end
        w_mix = enable ? w_sat[OUT_W-1:0] : '0;
    end

    // ------------------------------------------------------------------
    // Output register with valid/ready hold
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else if (!r_valid || out_ready) begin
            r_sample <= w_mix;
            r_valid  <= 1'b1;
        end
    end

    assign out_sample   = r_sample;
    assign out_valid    = r_valid;
    assign step_idx     = r_step_idx;
    assign step_pulse   = r_step_pulse;
    assign level        = r_level;
    assign voice_active = w_active;

endmodule
`default_nettype wire
